// File: rtl/je_pkg.sv
// je_pkg: shared definitions for the JPEG encoder conversion sequencer.
//   - je_state_t : sequencer state encoding
//   - ERR_*      : bit positions inside conv_err
//   - DEF_*      : default geometry / FIFO / sync parameters
//   - owns_rd()  : states in which prep owns the frame-memory read port
package je_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_PREP_REQ  = 4'd1,
    ST_PREP_WAIT = 4'd2,
    ST_ENC_EN    = 4'd3,
    ST_ENC_WAIT  = 4'd4,
    ST_DRAIN     = 4'd5,
    ST_OUT_REQ   = 4'd6,
    ST_OUT_WAIT  = 4'd7,
    ST_ABORT     = 4'd8
  } je_state_t;

  localparam int ERR_OVF  = 0;
  localparam int ERR_SIZE = 1;

  localparam int DEF_HEIGHT     = 200;
  localparam int DEF_WIDTH      = 320;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_DONE_SYNC  = 3;

  function automatic logic owns_rd(input je_state_t s);
    return (s == ST_PREP_WAIT) || (s == ST_ENC_EN) ||
           (s == ST_ENC_WAIT)  || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/je_wr_fifo.sv
// je_wr_fifo: single-clock show-ahead FIFO holding writer {address, data}.
// Ports:
//   clk, reset_n   : clock, async active-low reset
//   i_push, i_data : write request and entry
//   i_pop          : consume head entry (ignored when empty)
//   i_clear        : synchronous flush, beats push/pop
//   o_head         : current head entry (valid when !o_empty)
//   o_empty/o_full : occupancy flags
//   o_overflow     : one-cycle pulse when a push is dropped
module je_wr_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  input  logic         i_clear,
  output logic [W-1:0] o_head,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_pop;
  logic         w_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop && !o_empty;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_overflow = i_push && o_full && !w_pop && !i_clear;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/je_seq_ctrl.sv
// je_seq_ctrl: conversion sequencer for the JPEG encoder.
// Runs prep -> encode -> drain -> readout, single-shot or continuous, buffers
// writer output in je_wr_fifo and meters it into frame-memory write slots.
// Ports:
//   conv_start/mode/abort       : host request, mode (latched at start), abort
//   conv_busy/end/err/frame_cnt : status; conv_err sticky {size_sat, fifo_ovf}
//   prep_req/prep_ready         : frame preparation handshake
//   enc_en/enc_valid/enc_done   : encoder start, byte strobe, completion
//   wr_valid/wr_addr/wr_data    : writer push into the FIFO
//   mem_write_en/addr/data      : frame-memory write strobe from FIFO head
//   mem_wr_acc                  : memory write slot available
//   rd_sel/rd_start/rd_ack      : read-port owner, readout start, host ack
//   jpeg_size                   : byte count of the current/last frame
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for conv_start
// PREP_REQ  | prep_req pulse
// PREP_WAIT | waiting for prep_ready
// ENC_EN    | enc_en pulse, byte counter cleared
// ENC_WAIT  | counting bytes until delayed enc_done
// DRAIN     | flushing FIFO to memory
// OUT_REQ   | rd_start pulse, frame counted
// OUT_WAIT  | frame available to host
// ABORT     | aborted, waiting for conv_start low
module je_seq_ctrl
  import je_pkg::*;
#(
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ASZ        = $clog2(HEIGHT) + $clog2(WIDTH),
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DONE_SYNC  = DEF_DONE_SYNC
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           conv_start,
  input  logic           conv_mode,
  input  logic           conv_abort,
  output logic           conv_busy,
  output logic           conv_end,
  output logic [1:0]     conv_err,
  output logic [7:0]     frame_cnt,
  output logic           prep_req,
  input  logic           prep_ready,
  output logic           enc_en,
  input  logic           enc_valid,
  input  logic           enc_done,
  input  logic           wr_valid,
  input  logic [ASZ-1:0] wr_addr,
  input  logic [7:0]     wr_data,
  output logic           mem_write_en,
  output logic [ASZ-1:0] mem_write_addr,
  output logic [7:0]     mem_write_data,
  input  logic           mem_wr_acc,
  output logic           rd_sel,
  output logic           rd_start,
  input  logic           rd_ack,
  output logic [ASZ-1:0] jpeg_size
);

  localparam int FW = ASZ + 8;
  localparam logic [ASZ-1:0] SIZE_MAX = '1;

  je_state_t            r_state;
  je_state_t            w_state_next;
  logic                 r_mode;
  logic                 r_prep_req;
  logic                 r_enc_en;
  logic                 r_rd_start;
  logic                 r_mem_we;
  logic [ASZ-1:0]       r_jpeg_size;
  logic [7:0]           r_frame_cnt;
  logic [1:0]           r_err;
  logic [1:0]           w_err_next;
  logic [DONE_SYNC-1:0] r_done_sync;
  logic                 w_abort;
  logic                 w_start_frame;
  logic                 w_size_sat;
  logic                 w_ovf;
  logic                 w_empty;
  logic                 w_full;
  logic [FW-1:0]        w_head;
  logic                 w_write_ok;

  assign w_abort       = conv_abort && (r_state != ST_IDLE);
  assign w_start_frame = (r_state == ST_IDLE) && conv_start;
  assign w_size_sat    = (r_state == ST_ENC_WAIT) && enc_valid && (r_jpeg_size == SIZE_MAX);
  assign w_write_ok    = !w_empty && mem_wr_acc && !r_mem_we && !w_abort &&
                         ((r_state == ST_ENC_WAIT) || (r_state == ST_DRAIN));

  je_wr_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (wr_valid && (r_state != ST_ABORT)),
    .i_data     ({wr_addr, wr_data}),
    .i_pop      (r_mem_we),
    .i_clear    (w_abort),
    .o_head     (w_head),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_overflow (w_ovf)
  );

  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = ST_ABORT;
    end else begin
      case (r_state)
        ST_IDLE:      if (conv_start) w_state_next = ST_PREP_REQ;
        ST_PREP_REQ:  w_state_next = ST_PREP_WAIT;
        ST_PREP_WAIT: if (prep_ready) w_state_next = ST_ENC_EN;
        ST_ENC_EN:    w_state_next = ST_ENC_WAIT;
        ST_ENC_WAIT:  if (r_done_sync[DONE_SYNC-1]) w_state_next = ST_DRAIN;
        ST_DRAIN:     if (w_empty && !r_mem_we) w_state_next = ST_OUT_REQ;
        ST_OUT_REQ:   w_state_next = ST_OUT_WAIT;
        ST_OUT_WAIT: begin
          if (!conv_start)          w_state_next = ST_IDLE;
          else if (r_mode && rd_ack) w_state_next = ST_PREP_REQ;
        end
        ST_ABORT:     if (!conv_start) w_state_next = ST_IDLE;
        default:      w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_err_next = w_start_frame ? 2'b00 : r_err;
    if (w_ovf)      w_err_next[ERR_OVF]  = 1'b1;
    if (w_size_sat) w_err_next[ERR_SIZE] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= 1'b0;
      r_prep_req  <= 1'b0;
      r_enc_en    <= 1'b0;
      r_rd_start  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_jpeg_size <= '0;
      r_frame_cnt <= '0;
      r_err       <= '0;
      r_done_sync <= '0;
    end else begin
      r_state    <= w_state_next;
      // Pulses are decoded from the next state so they line up with the state.
      r_prep_req <= (w_state_next == ST_PREP_REQ);
      r_enc_en   <= (w_state_next == ST_ENC_EN);
      r_rd_start <= (w_state_next == ST_OUT_REQ);
      r_mem_we   <= w_write_ok;
      r_err      <= w_err_next;
      if (w_start_frame) r_mode <= conv_mode;
      if (r_state == ST_ENC_EN)
        r_jpeg_size <= '0;
      else if ((r_state == ST_ENC_WAIT) && enc_valid && (r_jpeg_size != SIZE_MAX))
        r_jpeg_size <= r_jpeg_size + ASZ'(1);
      if ((r_state == ST_OUT_REQ) && (w_state_next == ST_OUT_WAIT))
        r_frame_cnt <= r_frame_cnt + 8'd1;
      // A fresh encode discards any done still travelling from an earlier frame.
      if (r_state == ST_ENC_EN) begin
        r_done_sync <= '0;
      end else begin
        r_done_sync[0] <= enc_done;
        for (int i = 1; i < DONE_SYNC; i++) r_done_sync[i] <= r_done_sync[i-1];
      end
    end
  end

  assign conv_busy      = (r_state != ST_IDLE);
  assign conv_end       = (r_state == ST_OUT_WAIT);
  assign conv_err       = r_err;
  assign frame_cnt      = r_frame_cnt;
  assign prep_req       = r_prep_req;
  assign enc_en         = r_enc_en;
  assign rd_start       = r_rd_start;
  assign rd_sel         = owns_rd(r_state);
  assign jpeg_size      = r_jpeg_size;
  assign mem_write_en   = r_mem_we;
  assign mem_write_addr = r_mem_we ? w_head[FW-1:8] : '0;
  assign mem_write_data = r_mem_we ? w_head[7:0]    : '0;

endmodule

// File: tb/tb_je_seq_ctrl.sv
module tb_je_seq_ctrl;

  localparam int ASZ = 17;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           conv_start = 1'b0, conv_mode = 1'b0, conv_abort = 1'b0;
  logic           prep_ready = 1'b0, enc_valid = 1'b0, enc_done = 1'b0;
  logic           wr_valid = 1'b0, mem_wr_acc = 1'b0, rd_ack = 1'b0;
  logic [ASZ-1:0] wr_addr = '0;
  logic [7:0]     wr_data = '0;

  logic           conv_busy, conv_end, prep_req, enc_en, mem_write_en, rd_sel, rd_start;
  logic [1:0]     conv_err;
  logic [7:0]     frame_cnt, mem_write_data;
  logic [ASZ-1:0] mem_write_addr, jpeg_size;

  logic           busy4, end4, prq4, en4, we4, rsel4, rst4;
  logic [1:0]     err4;
  logic [7:0]     fc4, wd4;
  logic [3:0]     wa4, js4;

  int errors = 0, checks = 0;
  int strobe_cnt = 0, prep_cnt = 0, rd_cnt = 0, cyc = 0;
  int rd_cyc = 0, last_strobe_cyc = 0;
  logic prev_we = 1'b0;
  logic [ASZ+7:0] exp_q[$];
  logic [ASZ+7:0] exp_e;
  int s0, s1, r0, p0;

  always #5 clk = ~clk;

  je_seq_ctrl #(.ASZ(ASZ)) u_dut (
    .clk(clk), .reset_n(reset_n), .conv_start(conv_start), .conv_mode(conv_mode),
    .conv_abort(conv_abort), .conv_busy(conv_busy), .conv_end(conv_end),
    .conv_err(conv_err), .frame_cnt(frame_cnt), .prep_req(prep_req),
    .prep_ready(prep_ready), .enc_en(enc_en), .enc_valid(enc_valid),
    .enc_done(enc_done), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_wr_acc(mem_wr_acc), .rd_sel(rd_sel),
    .rd_start(rd_start), .rd_ack(rd_ack), .jpeg_size(jpeg_size)
  );

  je_seq_ctrl #(.ASZ(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .conv_start(conv_start), .conv_mode(conv_mode),
    .conv_abort(conv_abort), .conv_busy(busy4), .conv_end(end4),
    .conv_err(err4), .frame_cnt(fc4), .prep_req(prq4),
    .prep_ready(prep_ready), .enc_en(en4), .enc_valid(enc_valid),
    .enc_done(enc_done), .wr_valid(wr_valid), .wr_addr(wr_addr[3:0]), .wr_data(wr_data),
    .mem_write_en(we4), .mem_write_addr(wa4),
    .mem_write_data(wd4), .mem_wr_acc(mem_wr_acc), .rd_sel(rsel4),
    .rd_start(rst4), .rd_ack(rd_ack), .jpeg_size(js4)
  );

  // Monitor: pops the write scoreboard on every memory strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        cyc++;
        if (prep_req) prep_cnt++;
        if (rd_start) begin rd_cnt++; rd_cyc = cyc; end
        if (mem_write_en) begin
          strobe_cnt++;
          last_strobe_cyc = cyc;
          checks++;
          if (prev_we) begin
            errors++;
            $display("FAIL strobe_spacing: back-to-back mem_write_en at cycle %0d", cyc);
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: addr %0h data %0h, none expected",
                     mem_write_addr, mem_write_data);
          end else begin
            exp_e = exp_q.pop_front();
            if ({mem_write_addr, mem_write_data} !== exp_e) begin
              errors++;
              $display("FAIL write_entry: got addr %0h data %0h, expected addr %0h data %0h",
                       mem_write_addr, mem_write_data, exp_e[ASZ+7:8], exp_e[7:0]);
            end
          end
        end
        prev_we = mem_write_en;
      end else begin
        prev_we = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic sel(input int w);
    case (w)
      0: return prep_req;
      1: return enc_en;
      2: return rd_start;
      3: return !conv_busy;
      default: return conv_end;
    endcase
  endfunction

  task automatic wait_for(input int w, input int budget, input string name);
    int n = 0;
    while (!sel(w) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!sel(w)) begin
      errors++;
      $display("FAIL %s: not seen within %0d cycles, required 1", name, budget);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    conv_start = 0; conv_mode = 0; conv_abort = 0; prep_ready = 0;
    enc_valid = 0; enc_done = 0; wr_valid = 0; mem_wr_acc = 0; rd_ack = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(conv_busy), 0);
    chk("rst_jpeg", 32'(jpeg_size), 0);
    chk("rst_frame", 32'(frame_cnt), 0);
    chk("rst_err", 32'(conv_err), 0);
    chk("rst_pulses", 32'({prep_req, enc_en, rd_start, mem_write_en, rd_sel, conv_end}), 0);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic start_to_enc();
    wait_for(0, 5, "prep_req");
    repeat (10) tick();
    prep_ready = 1'b1;
    tick();
    prep_ready = 1'b0;
    wait_for(1, 3, "enc_en");
    tick();
  endtask

  task automatic push_bytes(input int n, input int n_q, input int gap, input int base,
                            input bit ev, input bit wv);
    for (int i = 0; i < n; i++) begin
      enc_valid = ev;
      wr_valid  = wv;
      wr_addr   = ASZ'(base + i);
      wr_data   = 8'(base + i * 5);
      if (wv && i < n_q) exp_q.push_back({wr_addr, wr_data});
      tick();
      enc_valid = 1'b0;
      wr_valid  = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic finish_enc(input int budget);
    enc_done = 1'b1;
    tick();
    enc_done = 1'b0;
    wait_for(2, budget, "rd_start");
  endtask

  initial begin
    // Single frame, 37 bytes
    do_reset();
    mem_wr_acc = 1; conv_start = 1;
    s0 = strobe_cnt; r0 = rd_cnt;
    start_to_enc();
    chk("t1_rd_sel", 32'(rd_sel), 1);
    push_bytes(37, 37, 1, 'h100, 1, 1);
    finish_enc(100);
    chk("t1_jpeg", 32'(jpeg_size), 37);
    chk("t1_strobes", 32'(strobe_cnt - s0), 37);
    chk("t1_queue", 32'(exp_q.size()), 0);
    chk("t1_err", 32'(conv_err), 0);
    tick();
    chk("t1_frame", 32'(frame_cnt), 1);
    chk("t1_end", 32'(conv_end), 1);
    chk("t1_rd_sel_out", 32'(rd_sel), 0);
    rd_ack = 1; tick(); rd_ack = 0;
    repeat (3) tick();
    chk("t1_end_hold", 32'(conv_end), 1);
    chk("t1_rd_once", 32'(rd_cnt - r0), 1);
    conv_start = 0;
    wait_for(3, 5, "t1_idle");
    chk("t1_end_off", 32'(conv_end), 0);

    // Continuous, three frames; mode changes after start must be ignored
    do_reset();
    conv_mode = 1; conv_start = 1; mem_wr_acc = 1;
    p0 = prep_cnt; r0 = rd_cnt;
    for (int f = 0; f < 3; f++) begin
      start_to_enc();
      if (f == 0) conv_mode = 0;
      push_bytes(3, 3, 1, 'h200 + f * 16, 1, 1);
      finish_enc(60);
      tick();
      rd_ack = 1;
      if (f == 2) conv_start = 0;
      tick();
      rd_ack = 0;
    end
    repeat (2) tick();
    chk("t2_frames", 32'(frame_cnt), 3);
    chk("t2_preps", 32'(prep_cnt - p0), 3);
    chk("t2_rds", 32'(rd_cnt - r0), 3);
    chk("t2_idle", 32'(conv_busy), 0);

    // Drain: writes blocked until after enc_done
    do_reset();
    conv_start = 1;
    s0 = strobe_cnt; r0 = rd_cnt;
    start_to_enc();
    push_bytes(5, 5, 0, 'h300, 1, 1);
    enc_done = 1; tick(); enc_done = 0;
    repeat (12) tick();
    chk("t3_no_strobe", 32'(strobe_cnt - s0), 0);
    chk("t3_no_rd", 32'(rd_cnt - r0), 0);
    chk("t3_busy", 32'(conv_busy), 1);
    mem_wr_acc = 1;
    wait_for(2, 40, "t3_rd_start");
    tick();
    chk("t3_strobes", 32'(strobe_cnt - s0), 5);
    chk("t3_order", 32'(rd_cyc > last_strobe_cyc), 1);
    conv_start = 0;
    wait_for(3, 5, "t3_idle");

    // Overflow: 17 pushes into 16 entries
    do_reset();
    conv_start = 1;
    s0 = strobe_cnt;
    start_to_enc();
    push_bytes(17, 16, 0, 'h400, 1, 1);
    chk("t4_err_ovf", 32'(conv_err), 1);
    enc_done = 1; tick(); enc_done = 0;
    mem_wr_acc = 1;
    wait_for(2, 80, "t4_rd_start");
    chk("t4_strobes", 32'(strobe_cnt - s0), 16);
    chk("t4_queue", 32'(exp_q.size()), 0);
    conv_start = 0;
    wait_for(3, 5, "t4_idle");
    chk("t4_sticky", 32'(conv_err), 1);

    // Abort in ENC_WAIT with 4 queued; new start clears errors
    mem_wr_acc = 0; conv_start = 1;
    r0 = rd_cnt;
    start_to_enc();
    chk("t5_err_clr", 32'(conv_err), 0);
    push_bytes(4, 4, 0, 'h500, 1, 1);
    s0 = strobe_cnt;
    conv_abort = 1; mem_wr_acc = 1;
    tick();
    conv_abort = 0;
    exp_q.delete();
    repeat (10) tick();
    chk("t5_no_strobe", 32'(strobe_cnt - s0), 0);
    chk("t5_busy", 32'(conv_busy), 1);
    chk("t5_end", 32'(conv_end), 0);
    enc_done = 1; tick(); enc_done = 0;
    repeat (8) tick();
    chk("t5_no_rd", 32'(rd_cnt - r0), 0);
    conv_start = 0;
    wait_for(3, 5, "t5_idle");
    conv_start = 1;
    s1 = strobe_cnt;
    start_to_enc();
    push_bytes(2, 2, 1, 'h580, 1, 1);
    finish_enc(40);
    chk("t5_fresh", 32'(strobe_cnt - s1), 2);
    conv_start = 0;
    wait_for(3, 5, "t5_idle2");

    // Reset asserted mid-frame
    conv_start = 1; mem_wr_acc = 0;
    start_to_enc();
    push_bytes(3, 0, 0, 'h600, 1, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_busy", 32'(conv_busy), 0);
    chk("mr_jpeg", 32'(jpeg_size), 0);
    chk("mr_rd_sel", 32'(rd_sel), 0);
    do_reset();

    // Byte-count saturation on the ASZ=4 instance
    conv_start = 1; mem_wr_acc = 1;
    start_to_enc();
    push_bytes(20, 0, 0, 'h700, 1, 0);
    chk("t6_jpeg", 32'(jpeg_size), 20);
    chk("t6_jpeg4", 32'(js4), 15);
    chk("t6_err4", 32'(err4[1]), 1);
    chk("t6_err", 32'(conv_err), 0);
    finish_enc(30);
    conv_start = 0;
    wait_for(3, 5, "t6_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
